// File: rtl/kbd_scan.sv
// kbd_scan: keyboard column scanner with settle FSM and per-key debounce.
// Define KBD_SCAN_IRQ_EN to add the key_irq/key_code press reporting outputs.
module kbd_scan #(
   parameter int SETTLE_CYCLES = 16,
   parameter int DEBOUNCE_CNT  = 20000
) (
   input  logic        sysclk,
   input  logic        poc_pad,
   input  logic [9:0]  col_sel,
   input  logic [39:0] key_raw,
   output logic [3:0]  row_out,
   output logic        settled,
   output logic        col_err
`ifdef KBD_SCAN_IRQ_EN
   ,
   output logic        key_irq,
   output logic [5:0]  key_code
`endif
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   typedef enum logic [1:0] {IDLE, SETTLE, TRACK} state_t;
   state_t               state, state_nxt;
   logic [9:0]           col_s1, col_s2, col_prev;
   logic [39:0]          key_s1, key_s2, db, db_nxt;
   logic [SW-1:0]        scnt, scnt_nxt;
   logic [3:0][DW-1:0]   rcnt, rcnt_nxt;
   logic [3:0]           col_idx, row_nxt;
   logic [5:0]           k;
   logic                 multi, one_hot, changed;
   always_comb begin
      multi     = |(col_s2 & (col_s2 - 10'd1));
      one_hot   = |col_s2 && !multi;
      changed   = col_s2 != col_prev;
      col_idx   = '0;
      for (int i = 0; i < 10; i++) if (col_s2[i]) col_idx = 4'(i);
      state_nxt = changed ? (one_hot ? SETTLE : IDLE) :
                  (state == SETTLE && int'(scnt) + 1 >= SETTLE_CYCLES - 1) ? TRACK : state;
      scnt_nxt  = changed ? '0 : (state == SETTLE && scnt != '1) ? scnt + 1'b1 : scnt;
      db_nxt    = db;
      rcnt_nxt  = '0;
      k         = '0;
      // Row counters only run while tracking a stable column; any column change clears them
      if (state == TRACK && !changed)
         for (int r = 0; r < 4; r++) begin
            k = {col_idx, 2'(r)};
            if (key_s2[k] != db[k]) begin
               if (int'(rcnt[r]) + 1 >= DEBOUNCE_CNT) db_nxt[k] = key_s2[k];
               else rcnt_nxt[r] = rcnt[r] + 1'b1;
            end
         end
      row_nxt = (state_nxt == TRACK) ? db[{col_idx, 2'b00} +: 4] : 4'b0;
   end
   always_ff @(posedge sysclk or posedge poc_pad)
      if (poc_pad) begin
         col_s1   <= '0;
         col_s2   <= '0;
         col_prev <= '0;
         key_s1   <= '0;
         key_s2   <= '0;
         state    <= IDLE;
         scnt     <= '0;
         rcnt     <= '0;
         db       <= '0;
         row_out  <= '0;
         settled  <= 1'b0;
         col_err  <= 1'b0;
      end else begin
         col_s1   <= col_sel;
         col_s2   <= col_s1;
         col_prev <= col_s2;
         key_s1   <= key_raw;
         key_s2   <= key_s1;
         state    <= state_nxt;
         scnt     <= scnt_nxt;
         rcnt     <= rcnt_nxt;
         db       <= db_nxt;
         row_out  <= row_nxt;
         settled  <= state_nxt == TRACK;
         col_err  <= multi;
      end
`ifdef KBD_SCAN_IRQ_EN
   logic [39:0] pend, pend_c;
   logic [5:0]  code_nxt;
   // Presses not yet reported stay pending until reported or released; lowest index goes first
   always_comb begin
      pend_c   = (pend | (db_nxt & ~db)) & db_nxt;
      code_nxt = '0;
      for (int i = 39; i >= 0; i--) if (pend_c[i]) code_nxt = 6'(i);
   end
   always_ff @(posedge sysclk or posedge poc_pad)
      if (poc_pad) begin
         pend     <= '0;
         key_irq  <= 1'b0;
         key_code <= '0;
      end else begin
         pend     <= pend_c & ~(40'(|pend_c) << code_nxt);
         key_irq  <= |pend_c;
         key_code <= |pend_c ? code_nxt : key_code;
      end
`endif
endmodule

// File: tb/tb_kbd_scan.sv
// tb_kbd_scan: scoreboard bench for kbd_scan (SETTLE_CYCLES=4, DEBOUNCE_CNT=3).
module tb_kbd_scan;
   logic        sysclk = 1'b0;
   logic        poc_pad = 1'b1;
   logic [9:0]  col_sel = '0;
   logic [39:0] key_raw = '0;
   logic [3:0]  row_out;
   logic        settled, col_err;
   logic [5:0]  obs;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   typedef struct {
      int         due;
      string      tag;
      logic [5:0] exp;
   } ent_t;
   ent_t sb[$];
`ifdef KBD_SCAN_IRQ_EN
   logic        key_irq;
   logic [5:0]  key_code;
   int          irq_n = 0;
   logic [5:0]  irq_code = '0;
`endif
   kbd_scan #(.SETTLE_CYCLES(4), .DEBOUNCE_CNT(3)) dut (
      .sysclk(sysclk),
      .poc_pad(poc_pad),
      .col_sel(col_sel),
      .key_raw(key_raw),
      .row_out(row_out),
      .settled(settled),
      .col_err(col_err)
`ifdef KBD_SCAN_IRQ_EN
      ,
      .key_irq(key_irq),
      .key_code(key_code)
`endif
   );
   assign obs = {row_out, settled, col_err};
   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic push(input string tag, input int dly, input logic [5:0] exp);
      ent_t e;
      e.due = cyc + dly;
      e.tag = tag;
      e.exp = exp;
      sb.push_back(e);
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask
   // Expected {row_out, settled, col_err} are checked on the falling edge of their due cycle
   always @(negedge sysclk)
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         ent_t e;
         e = sb.pop_front();
         chk(e.tag, 32'(obs), 32'(e.exp));
      end
`ifdef KBD_SCAN_IRQ_EN
   always @(negedge sysclk)
      if (key_irq) begin
         irq_n    <= irq_n + 1;
         irq_code <= key_code;
      end
`endif
   initial begin
`ifdef KBD_SCAN_IRQ_EN
      int n0;
`endif
      tick(3);
      chk("reset_outs", 32'(obs), 32'h0);
`ifdef KBD_SCAN_IRQ_EN
      chk("reset_irq", 32'({key_irq, key_code}), 32'h0);
`endif
      poc_pad = 1'b0;
      col_sel = 10'h001;
      push("settle_pre", 5, 6'b0000_0_0);
      push("settle_rise", 6, 6'b0000_1_0);
      tick(8);
      push("toggle_a", 4, 6'b0000_1_0);
      push("toggle_b", 7, 6'b0000_1_0);
      push("toggle_c", 10, 6'b0000_1_0);
      push("toggle_d", 14, 6'b0000_1_0);
      for (int i = 0; i < 10; i++) begin
         key_raw[2] = (i % 2 == 0);
         tick(1);
      end
      tick(6);
      key_raw[2] = 1'b1;
      push("deb_pre", 5, 6'b0000_1_0);
      push("deb_hit", 6, 6'b0100_1_0);
      tick(8);
      col_sel = 10'h002;
      push("col1_old", 2, 6'b0100_1_0);
      push("col1_settle", 3, 6'b0000_0_0);
      push("col1_track", 6, 6'b0000_1_0);
      tick(1);
      key_raw[2] = 1'b0;
      tick(7);
      col_sel = 10'h001;
      push("col0_settle", 3, 6'b0000_0_0);
      push("col0_restore", 6, 6'b0100_1_0);
      push("rel_pre", 9, 6'b0100_1_0);
      push("rel_hit", 10, 6'b0000_1_0);
      tick(12);
      col_sel = 10'h003;
      push("multi_pre", 2, 6'b0000_1_0);
      push("multi_err", 3, 6'b0000_0_1);
      tick(6);
      col_sel = 10'h000;
      push("zero_pre", 2, 6'b0000_0_1);
      push("zero_idle", 3, 6'b0000_0_0);
      tick(6);
      col_sel = 10'h001;
      push("rst_prep", 6, 6'b0000_1_0);
      tick(8);
      key_raw[1] = 1'b1;
      tick(4);
      #2 poc_pad = 1'b1;
      #1 chk("reset_async", 32'(obs), 32'h0);
      tick(3);
      poc_pad = 1'b0;
      push("post_settle", 6, 6'b0000_1_0);
      push("post_pre", 9, 6'b0000_1_0);
      push("post_hit", 10, 6'b0010_1_0);
      tick(12);
`ifdef KBD_SCAN_IRQ_EN
      n0 = irq_n;
`endif
      key_raw = 40'd1 << 9;
      col_sel = 10'h004;
      push("col2_settle", 6, 6'b0000_1_0);
      push("key9_pre", 9, 6'b0000_1_0);
      push("key9_hit", 10, 6'b0010_1_0);
      tick(14);
`ifdef KBD_SCAN_IRQ_EN
      chk("irq_count", 32'(irq_n - n0), 32'd1);
      chk("irq_code", 32'(irq_code), 32'd9);
`endif
      for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
      if (sb.size() > 0) chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/kbd_scan.md
KBD_SCAN -- requirements
Module: kbd_scan

Interface
REQ-001 SETTLE_CYCLES, default 16: cycles a new column select must stay stable before row sampling starts.
REQ-002 DEBOUNCE_CNT, default 20000: consecutive differing samples needed to flip a debounced key bit; range 1..65535.
REQ-003 sysclk  input  1  system clock; all state changes on its rising edge.
REQ-004 poc_pad  input  1  reset, asynchronous, active-high.
REQ-005 col_sel  input  10  column strobe from the 4003 shift register parallel output, active-high, one-hot when valid.
REQ-006 key_raw  input  40  raw switch matrix, 1 = pressed; bit index = col*4 + row.
REQ-007 row_out  output  4  debounced row nibble of the active column, to the ROM input port.
REQ-008 settled  output  1  high while in TRACK; row_out is valid for the current column.
REQ-009 col_err  output  1  high while col_sel has more than one bit set.

Function
REQ-010 col_sel and key_raw shall pass through a 2-flop synchronizer before use; all latencies below count from the synchronized value.
REQ-011 FSM states: IDLE, SETTLE, TRACK.
- IDLE: synchronized col_sel not one-hot.
- SETTLE: one-hot column, counting stable cycles.
- TRACK: sampling and debouncing.
REQ-012 Any cycle where synchronized col_sel differs from the previous cycle's value:
- one-hot -> SETTLE, settle counter = 0
- otherwise -> IDLE
This applies from every state.
REQ-013 SETTLE -> TRACK when the settle counter reaches SETTLE_CYCLES-1 with col_sel unchanged; settled rises the same edge.
REQ-014 In TRACK, for each row r of active column c, compare key_raw[c*4+r] with debounced bit db[c*4+r].
- Equal: row counter r cleared.
- Differs: row counter r incremented.
- Counter reaches DEBOUNCE_CNT: db bit takes the raw value, counter cleared.
REQ-015 On every column change (REQ-012), all four row counters shall clear; db bits of all columns are retained.
REQ-016 row_out is registered.
- TRACK: equals db[c*4+3 : c*4], updated the cycle after a db change.
- IDLE and SETTLE: 0.
REQ-017 col_err is registered, high exactly while synchronized col_sel has two or more bits set.
REQ-018 When col_sel is all-zero: state IDLE, col_err = 0, row_out = 0.
REQ-019 Counter widths shall hold DEBOUNCE_CNT without wrap; the settle counter saturates and does not wrap.

Reset
REQ-020 poc_pad high shall immediately force:
- state IDLE
- row_out = 0, settled = 0, col_err = 0
- all 40 db bits = 0
- all counters = 0
- synchronizers = 0
REQ-021 A reset asserted mid-debounce or mid-settle shall discard the partial count; after release, operation restarts from IDLE, with the first column change seen 2 cycles later through the synchronizer.

Configuration
REQ-022 Macro KBD_SCAN_IRQ_EN.
- Defined: add outputs key_irq (1 bit) and key_code (6 bits). key_irq pulses for one cycle when any db bit goes 0->1, and key_code = c*4+r of that key. If several rows press in the same cycle, the lowest row index wins and the rest are reported on following cycles while still pressed and unreported. key_irq and key_code reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Verification
Bench parameters: SETTLE_CYCLES=4, DEBOUNCE_CNT=3.
REQ-023 Reset release, col_sel=10'h001, key_raw=0 -> settled rises on the 6th edge after col_sel is applied (2 sync + 4 settle); row_out=0.
REQ-024 Column 0 in TRACK, key_raw[2]=1 held -> row_out=4'b0100 on the 4th edge after the synchronized change (3 counts + 1 register).
REQ-025 key_raw[2] toggles 1,0,1,0 each cycle in TRACK -> row_out stays 0 (counter never reaches 3).
REQ-026 Column 0 holds db=4'b0100; col_sel goes to 10'h002, then back to 10'h001 -> row_out 0 during SETTLE, then 4'b0100 restored without re-debounce.
REQ-027 col_sel=10'h003 -> col_err=1, settled=0, row_out=0; then col_sel=10'h000 -> col_err=0, state IDLE.
REQ-028 poc_pad pulses after 2 of 3 debounce counts -> outputs 0 immediately; after release the key needs a full 3 counts. With KBD_SCAN_IRQ_EN, key 9 pressed in column 2 -> one key_irq pulse with key_code=6'd9.
